// File: rtl/guess_scoreboard.sv
// Word-guess scoreboard: tracks used letters, revealed positions, misses and win/lose state.
// Latency 1 cycle from guess_valid to outputs; no backpressure, every strobe is consumed.
module guess_scoreboard #(
    parameter int MAX_MISSES = 6,
    parameter int NUM_POS    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               guess_valid,
    input  logic [4:0]         guess,
    input  logic [NUM_POS-1:0] hit_mask,
    input  logic [NUM_POS-1:0] word_mask,
    output logic [NUM_POS-1:0] revealed,
    output logic [3:0]         misses,
    output logic [9:0]         lives_led,
    output logic               win,
    output logic               lose,
    output logic               dup_pulse,
    output logic               bad_pulse
);

    localparam logic [3:0] MAX_M = 4'(MAX_MISSES);

    typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

    state_t             state, state_nxt;
    logic [25:0]        used, used_nxt;
    logic [NUM_POS-1:0] revealed_nxt;
    logic [NUM_POS-1:0] hits;
    logic [3:0]         misses_nxt;
    logic [3:0]         lives;
    logic               dup_nxt, bad_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            used      <= '0;
            revealed  <= '0;
            misses    <= '0;
            dup_pulse <= 1'b0;
            bad_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            used      <= used_nxt;
            revealed  <= revealed_nxt;
            misses    <= misses_nxt;
            dup_pulse <= dup_nxt;
            bad_pulse <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        used_nxt     = used;
        revealed_nxt = revealed;
        misses_nxt   = misses;
        dup_nxt      = 1'b0;
        bad_nxt      = 1'b0;
        hits         = hit_mask & word_mask;
        if (new_game) begin
            state_nxt    = PLAY;
            used_nxt     = '0;
            revealed_nxt = '0;
            misses_nxt   = '0;
        end else if (state == PLAY && guess_valid) begin
            if (guess > 5'd25) begin
                bad_nxt = 1'b1;
            end else if (used[guess]) begin
                dup_nxt = 1'b1;
            end else begin
                used_nxt[guess] = 1'b1;
                if (hits != '0) begin
                    revealed_nxt = revealed | hits;
                    if (word_mask != '0 && (revealed_nxt & word_mask) == word_mask)
                        state_nxt = WIN;
                end else begin
                    // Saturate rather than wrap; reaching the limit ends the round.
                    if (misses < MAX_M)
                        misses_nxt = misses + 4'd1;
                    if (misses_nxt == MAX_M)
                        state_nxt = LOSE;
                end
            end
        end
    end

    assign win  = (state == WIN);
    assign lose = (state == LOSE);

    assign lives = MAX_M - misses;

    always_comb begin
        lives_led = '0;
        for (int i = 0; i < 10; i++)
            lives_led[i] = (i < int'(lives));
    end

endmodule

// File: tb/tb_guess_scoreboard.sv
// Bench for guess_scoreboard: directed scenarios plus randomized play against a behavioural model.
module tb_guess_scoreboard;

    localparam int MAXM = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       guess_valid = 1'b0;
    logic [4:0] guess = '0;
    logic [4:0] hit_mask = '0;
    logic [4:0] word_mask = '0;
    logic [4:0] revealed;
    logic [3:0] misses;
    logic [9:0] lives_led;
    logic       win, lose, dup_pulse, bad_pulse;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit         m_used[26];
    logic [4:0] m_rev;
    int         m_miss;
    bit         m_won, m_lost, m_dup, m_bad;

    guess_scoreboard #(.MAX_MISSES(MAXM), .NUM_POS(5)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .guess_valid(guess_valid),
        .guess(guess), .hit_mask(hit_mask), .word_mask(word_mask),
        .revealed(revealed), .misses(misses), .lives_led(lives_led),
        .win(win), .lose(lose), .dup_pulse(dup_pulse), .bad_pulse(bad_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_lives(input int m);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < MAXM - m; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 26; i++) m_used[i] = 0;
        m_rev = '0; m_miss = 0; m_won = 0; m_lost = 0; m_dup = 0; m_bad = 0;
    endtask

    task automatic model_apply(input bit ng, input bit gv, input int g,
                               input logic [4:0] hm, input logic [4:0] wm);
        logic [4:0] h;
        m_dup = 0;
        m_bad = 0;
        h = hm & wm;
        if (ng) begin
            model_clear();
        end else if (gv && !m_won && !m_lost) begin
            if (g > 25) m_bad = 1;
            else if (m_used[g]) m_dup = 1;
            else begin
                m_used[g] = 1;
                if (h != 0) begin
                    m_rev = m_rev | h;
                    if (wm != 0 && (m_rev & wm) == wm) m_won = 1;
                end else begin
                    m_miss = (m_miss < MAXM) ? m_miss + 1 : MAXM;
                    if (m_miss == MAXM) m_lost = 1;
                end
            end
        end
    endtask

    // One clock of stimulus; outputs are sampled 1ns after the edge.
    task automatic drive(input bit ng, input bit gv, input int g,
                         input logic [4:0] hm, input logic [4:0] wm);
        new_game = ng; guess_valid = gv; guess = 5'(g); hit_mask = hm; word_mask = wm;
        @(posedge clk); #1;
        new_game = 0; guess_valid = 0;
        model_apply(ng, gv, g, hm, wm);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (revealed !== 5'b0 || misses !== 4'd0 || win !== 1'b0 || lose !== 1'b0 ||
            dup_pulse !== 1'b0 || bad_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rev=%b miss=%0d win=%b lose=%b dup=%b bad=%b, want all zero",
                     revealed, misses, win, lose, dup_pulse, bad_pulse);
        end
        checks++;
        if (lives_led !== 10'b0000111111) begin
            failures++;
            $display("FAIL reset_lives: got %b want 0000111111", lives_led);
        end
    endtask

    task automatic test_win();
        int         letters[4] = '{18, 19, 0, 24};
        logic [4:0] pos[4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
        drive(1, 0, 0, 0, 5'b01111);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, letters[i], pos[i], 5'b01111);
            checks++;
            if (revealed !== m_rev || win !== m_won) begin
                failures++;
                $display("FAIL win_step%0d: rev=%b win=%b want rev=%b win=%b",
                         i, revealed, win, m_rev, m_won);
            end
        end
        checks++;
        if (revealed !== 5'b01111 || win !== 1'b1 || lose !== 1'b0 || misses !== 4'd0) begin
            failures++;
            $display("FAIL win_final: rev=%b win=%b lose=%b miss=%0d want 01111 1 0 0",
                     revealed, win, lose, misses);
        end
    endtask

    task automatic test_lose();
        drive(1, 0, 0, 0, 5'b01111);
        for (int i = 1; i <= 7; i++) begin
            drive(0, 1, i + 2, 5'b00000, 5'b01111);
            checks++;
            if (misses !== 4'(m_miss) || lose !== m_lost || lives_led !== exp_lives(m_miss)) begin
                failures++;
                $display("FAIL lose_step%0d: miss=%0d lose=%b leds=%b want %0d %b %b",
                         i, misses, lose, lives_led, m_miss, m_lost, exp_lives(m_miss));
            end
        end
        checks++;
        if (misses !== 4'd6 || lose !== 1'b1 || win !== 1'b0 || lives_led !== 10'd0) begin
            failures++;
            $display("FAIL lose_final: miss=%0d lose=%b win=%b leds=%b want 6 1 0 0",
                     misses, lose, win, lives_led);
        end
    endtask

    task automatic test_dup();
        drive(1, 0, 0, 0, 5'b01111);
        drive(0, 1, 4, 5'b00000, 5'b01111);
        drive(0, 1, 4, 5'b00001, 5'b01111);
        checks++;
        if (dup_pulse !== 1'b1 || misses !== 4'd1 || revealed !== 5'b0 || bad_pulse !== 1'b0) begin
            failures++;
            $display("FAIL dup_pulse: dup=%b miss=%0d rev=%b bad=%b want 1 1 00000 0",
                     dup_pulse, misses, revealed, bad_pulse);
        end
        drive(0, 0, 0, 0, 5'b01111);
        checks++;
        if (dup_pulse !== 1'b0) begin
            failures++;
            $display("FAIL dup_one_cycle: dup=%b want 0", dup_pulse);
        end
    endtask

    task automatic test_bad();
        drive(0, 1, 27, 5'b00010, 5'b01111);
        checks++;
        if (bad_pulse !== 1'b1 || dup_pulse !== 1'b0 || misses !== 4'd1 || revealed !== 5'b0) begin
            failures++;
            $display("FAIL bad_pulse: bad=%b dup=%b miss=%0d rev=%b want 1 0 1 00000",
                     bad_pulse, dup_pulse, misses, revealed);
        end
        drive(0, 0, 0, 0, 5'b01111);
        checks++;
        if (bad_pulse !== 1'b0) begin
            failures++;
            $display("FAIL bad_one_cycle: bad=%b want 0", bad_pulse);
        end
    endtask

    task automatic test_newgame_priority();
        drive(1, 0, 0, 0, 5'b01111);
        for (int i = 0; i < 6; i++) drive(0, 1, 10 + i, 5'b00000, 5'b01111);
        checks++;
        if (lose !== 1'b1) begin
            failures++;
            $display("FAIL ng_setup_lose: lose=%b want 1", lose);
        end
        drive(1, 1, 20, 5'b00001, 5'b01111);
        checks++;
        if (lose !== 1'b0 || win !== 1'b0 || revealed !== 5'b0 || misses !== 4'd0 ||
            lives_led !== 10'b0000111111) begin
            failures++;
            $display("FAIL ng_over_guess: lose=%b win=%b rev=%b miss=%0d leds=%b want 0 0 0 0 0000111111",
                     lose, win, revealed, misses, lives_led);
        end
        drive(0, 1, 10, 5'b00000, 5'b01111);
        checks++;
        if (dup_pulse !== 1'b0 || misses !== 4'd1) begin
            failures++;
            $display("FAIL ng_used_cleared: dup=%b miss=%0d want 0 1", dup_pulse, misses);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 5'b01111);
        drive(0, 1, 7, 5'b00001, 5'b01111);
        do_reset();
        checks++;
        if (revealed !== 5'b0 || misses !== 4'd0 || win !== 1'b0 || lose !== 1'b0 ||
            dup_pulse !== 1'b0 || bad_pulse !== 1'b0 || lives_led !== 10'b0000111111) begin
            failures++;
            $display("FAIL reset_mid: rev=%b miss=%0d win=%b lose=%b dup=%b bad=%b leds=%b",
                     revealed, misses, win, lose, dup_pulse, bad_pulse, lives_led);
        end
        drive(0, 1, 7, 5'b00001, 5'b01111);
        checks++;
        if (dup_pulse !== 1'b0 || revealed !== 5'b00001) begin
            failures++;
            $display("FAIL reset_used_cleared: dup=%b rev=%b want 0 00001", dup_pulse, revealed);
        end
    endtask

    task automatic test_random();
        logic [4:0] wm;
        wm = 5'b11111;
        drive(1, 0, 0, 0, wm);
        for (int n = 0; n < 600; n++) begin
            bit ng, gv;
            int g;
            ng = ($urandom_range(0, 24) == 0);
            if (ng) wm = 5'($urandom_range(1, 31));
            gv = ($urandom_range(0, 3) != 0);
            g  = ($urandom_range(0, 9) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            drive(ng, gv, g, 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)), wm);
            checks++;
            if (revealed !== m_rev || misses !== 4'(m_miss) || win !== m_won || lose !== m_lost ||
                dup_pulse !== m_dup || bad_pulse !== m_bad || lives_led !== exp_lives(m_miss)) begin
                failures++;
                $display("FAIL random_%0d: rev=%b miss=%0d w=%b l=%b d=%b b=%b leds=%b want %b %0d %b %b %b %b %b",
                         n, revealed, misses, win, lose, dup_pulse, bad_pulse, lives_led,
                         m_rev, m_miss, m_won, m_lost, m_dup, m_bad, exp_lives(m_miss));
            end
            checks++;
            if ((win && lose) || (dup_pulse && bad_pulse)) begin
                failures++;
                $display("FAIL random_exclusive_%0d: win=%b lose=%b dup=%b bad=%b want no pair high",
                         n, win, lose, dup_pulse, bad_pulse);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_win();
        test_lose();
        test_dup();
        test_bad();
        test_newgame_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_scoreboard.md
GUESS_SCOREBOARD -- requirements
Module: guess_scoreboard

Interface
REQ-001 Parameter MAX_MISSES, default 6, SHALL set the number of wrong guesses that ends the game (legal range 1..10).
REQ-002 Parameter NUM_POS, default 5, SHALL set the number of letter positions tracked.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 new_game  input  1  SHALL be a synchronous clear to start a new round (level-sampled).
REQ-006 guess_valid  input  1  SHALL be a one-cycle strobe from the letter-compare stage marking a resolved guess.
REQ-007 guess  input  5  SHALL be the letter code, 0=A .. 25=Z; codes 26..31 are illegal.
REQ-008 hit_mask  input  NUM_POS  SHALL give one bit per position matched by guess (the l1..l5 enables from the compare stage).
REQ-009 word_mask  input  NUM_POS  SHALL mark the positions in use (for example 5'b01111 for a 4-letter word).
REQ-010 revealed  output  NUM_POS  SHALL hold the positions guessed so far.
REQ-011 misses  output  4  SHALL hold the wrong-guess count.
REQ-012 lives_led  output  10  SHALL be a thermometer of remaining lives: the low (MAX_MISSES-misses) bits set, all other bits clear.
REQ-013 win, lose  output  1 each  SHALL be the terminal-state flags.
REQ-014 dup_pulse, bad_pulse  output  1 each  SHALL be one-cycle indications that a guess was a repeat or illegal.

Function
REQ-015 The FSM SHALL have exactly three states: PLAY, WIN and LOSE.
REQ-016 guess_valid SHALL have effect only in PLAY; in WIN and LOSE it SHALL be ignored, with no register change and no pulse.
REQ-017 A guess SHALL be illegal when guess>25: on the next edge bad_pulse=1 and no other state changes.
REQ-018 A 26-bit used-letter register SHALL record every legal guess accepted in PLAY.
REQ-019 A legal guess whose used bit is already set SHALL be a duplicate:
- dup_pulse=1 on the next edge;
- revealed, misses and the FSM state SHALL be unchanged.
REQ-020 A legal, non-duplicate guess SHALL set its used bit, and:
- if (hit_mask & word_mask)!=0, revealed SHALL update to revealed | (hit_mask & word_mask);
- otherwise misses SHALL increment by 1.
REQ-021 hit_mask bits outside word_mask SHALL be ignored; a guess hitting only unused positions SHALL count as a miss.
REQ-022 Latency: all outputs SHALL reflect a guess on the first rising edge after the guess_valid cycle.
REQ-023 The transition PLAY->WIN SHALL occur on that same edge when word_mask!=0 and (updated revealed & word_mask)==word_mask.
REQ-024 The transition PLAY->LOSE SHALL occur on that same edge when the updated misses equals MAX_MISSES.
REQ-025 misses SHALL never exceed MAX_MISSES (it saturates) and SHALL never wrap.
REQ-026 When word_mask==0, the FSM SHALL stay in PLAY and every legal, non-duplicate guess SHALL count as a miss.
REQ-027 win SHALL be 1 exactly in WIN and lose SHALL be 1 exactly in LOSE; they SHALL never both be 1.
REQ-028 dup_pulse and bad_pulse SHALL be mutually exclusive and SHALL each last exactly one cycle per qualifying guess.
REQ-029 new_game=1 SHALL on the next edge clear revealed, misses, the used-letter register and both pulses, and SHALL set state to PLAY, from any state.
REQ-030 When new_game and guess_valid are high in the same cycle, new_game SHALL win and the guess SHALL be discarded.
REQ-031 word_mask SHALL be treated as stable between new_game events; a change mid-round SHALL only affect guesses evaluated afterwards.

Reset
REQ-032 reset=1 SHALL on the next edge set revealed=0, misses=0, used=0, win=0, lose=0, dup_pulse=0, bad_pulse=0, state=PLAY, and lives_led to MAX_MISSES ones (10'b0000111111 at the default).
REQ-033 reset SHALL take priority over new_game and guess_valid.
REQ-034 reset asserted mid-round SHALL discard the round completely.
REQ-035 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-036 Setup word_mask=01111, MAX_MISSES=6; guess 18 with hit_mask=00001, then 19 with hit_mask=00010, then 0 with hit_mask=00100, then 24 with hit_mask=01000 -> revealed=01111, win=1 one cycle after the fourth strobe, misses=0.
REQ-037 Six guesses of distinct letters with hit_mask=0 -> misses counts 1..6, lose=1 after the sixth, lives_led=0; a seventh strobe changes nothing.
REQ-038 Guess 4 as a miss, then guess 4 again -> misses=1, dup_pulse high for exactly one cycle.
REQ-039 Guess 27 -> bad_pulse for one cycle; misses, revealed and used unchanged.
REQ-040 Same-cycle new_game and guess_valid (hit) while in LOSE -> next cycle PLAY, revealed=0, misses=0, lives_led=0000111111.
REQ-041 reset asserted in the cycle after a hit on position 0 -> all outputs at their reset values; regardless of that earlier hit, a new guess of the same letter is not flagged duplicate.
